// File: rtl/marker_pkg.sv
// Shared types for the scanline marker logic: scan FSM states and the
// per-line result record consumed by downstream marker candidate logic.
package marker_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_t;

  localparam int RES_COORD_WIDTH = 11;
  localparam int RES_FLIP_WIDTH  = 4;

  // Field widths match the default scanner configuration.
  typedef struct packed {
    logic [RES_FLIP_WIDTH-1:0]  number_of_flips;
    logic                       overflow;
    logic [RES_COORD_WIDTH-1:0] first_coord;
    logic [RES_COORD_WIDTH-1:0] last_coord;
    logic [RES_COORD_WIDTH-1:0] centre_coord;
    logic [RES_COORD_WIDTH-1:0] widest_run;
    logic [RES_COORD_WIDTH-1:0] widest_run_start;
  } line_result_t;

endpackage

// File: rtl/run_debouncer.sv
// Colour-change debouncer: a new colour becomes stable only after MIN_RUN
// consecutive pixels; the flip is reported at the coordinate where it began.
module run_debouncer #(
  parameter int PIXEL_WIDTH = 3,
  parameter int COORD_WIDTH = 11,
  parameter int MIN_RUN     = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   accept,
  input  logic                   line_start,
  input  logic [PIXEL_WIDTH-1:0] pixel,
  input  logic [COORD_WIDTH-1:0] coord,
  output logic                   flip,
  output logic [COORD_WIDTH-1:0] flip_coord
);

  localparam int CNT_WIDTH = (MIN_RUN < 2) ? 1 : $clog2(MIN_RUN + 1);

  logic [PIXEL_WIDTH-1:0] stable, stable_n;
  logic [PIXEL_WIDTH-1:0] cand, cand_n;
  logic [CNT_WIDTH-1:0]   cand_count, cand_count_n, count_inc;
  logic [COORD_WIDTH-1:0] cand_start, cand_start_n;

  // A zero cand_count means no candidate is pending.
  always_comb begin
    flip         = 1'b0;
    flip_coord   = cand_start;
    stable_n     = stable;
    cand_n       = cand;
    cand_count_n = cand_count;
    cand_start_n = cand_start;
    count_inc    = cand_count + CNT_WIDTH'(1);
    if (accept) begin
      if (line_start) begin
        stable_n     = pixel;
        cand_n       = '0;
        cand_count_n = '0;
        cand_start_n = '0;
      end else if (pixel == stable) begin
        cand_n       = '0;
        cand_count_n = '0;
        cand_start_n = '0;
      end else if ((cand_count != '0) && (pixel == cand)) begin
        if (count_inc == CNT_WIDTH'(MIN_RUN)) begin
          flip         = 1'b1;
          flip_coord   = cand_start;
          stable_n     = cand;
          cand_n       = '0;
          cand_count_n = '0;
          cand_start_n = '0;
        end else begin
          cand_count_n = count_inc;
        end
      end else if (MIN_RUN == 1) begin
        flip         = 1'b1;
        flip_coord   = coord;
        stable_n     = pixel;
        cand_n       = '0;
        cand_count_n = '0;
        cand_start_n = '0;
      end else begin
        cand_n       = pixel;
        cand_count_n = CNT_WIDTH'(1);
        cand_start_n = coord;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      stable     <= '0;
      cand       <= '0;
      cand_count <= '0;
      cand_start <= '0;
    end else begin
      stable     <= stable_n;
      cand       <= cand_n;
      cand_count <= cand_count_n;
      cand_start <= cand_start_n;
    end
  end

endmodule

// File: rtl/run_length_marker_scan.sv
// Per-scanline flip statistics over debounced colour changes, published
// with a one-cycle done pulse the cycle after the last pixel of a line.
module run_length_marker_scan
  import marker_pkg::*;
#(
  parameter int  PIXEL_WIDTH = 3,
  parameter int  COORD_WIDTH = 11,
  parameter int  LINE_LENGTH = 1680,
  parameter int  MAX_FLIPS   = 15,
  parameter int  MIN_RUN     = 2,
  localparam int FLIP_WIDTH  = $clog2(MAX_FLIPS + 1)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   pixel_valid_in,
  input  logic                   line_start_in,
  input  logic [PIXEL_WIDTH-1:0] rgb_in,
  output logic [FLIP_WIDTH-1:0]  number_of_flips_out,
  output logic                   overflow_out,
  output logic [COORD_WIDTH-1:0] first_coord_out,
  output logic [COORD_WIDTH-1:0] last_coord_out,
  output logic [COORD_WIDTH-1:0] centre_coord_out,
  output logic [COORD_WIDTH-1:0] widest_run_out,
  output logic [COORD_WIDTH-1:0] widest_run_start_out,
  output logic                   done_out,
  output scan_state_t            state_out
);

  scan_state_t state;

  logic [COORD_WIDTH-1:0] coord_q, cur_coord;
  logic                   accept, line_end;
  logic                   flip;
  logic [COORD_WIDTH-1:0] flip_coord;

  logic [FLIP_WIDTH-1:0]  cnt_q, cnt_b, cnt_n;
  logic                   ovf_q, ovf_b, ovf_n;
  logic [COORD_WIDTH-1:0] first_q, first_b, first_n;
  logic [COORD_WIDTH-1:0] last_q, last_b, last_n;
  logic [COORD_WIDTH-1:0] widest_q, widest_b, widest_n;
  logic [COORD_WIDTH-1:0] wstart_q, wstart_b, wstart_n;
  logic [COORD_WIDTH-1:0] run;
  logic [COORD_WIDTH:0]   centre_sum;

  // A line start is honoured in either state, so a restart needs no idle gap.
  assign accept    = pixel_valid_in & (line_start_in | (state == ST_SCAN));
  assign cur_coord = line_start_in ? '0 : coord_q;
  assign line_end  = accept && (cur_coord == COORD_WIDTH'(LINE_LENGTH - 1));
  assign state_out = state;

  run_debouncer #(
    .PIXEL_WIDTH (PIXEL_WIDTH),
    .COORD_WIDTH (COORD_WIDTH),
    .MIN_RUN     (MIN_RUN)
  ) u_debouncer (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .accept     (accept),
    .line_start (line_start_in),
    .pixel      (rgb_in),
    .coord      (cur_coord),
    .flip       (flip),
    .flip_coord (flip_coord)
  );

  always_comb begin
    if (line_start_in) begin
      cnt_b    = '0;
      ovf_b    = 1'b0;
      first_b  = '0;
      last_b   = '0;
      widest_b = '0;
      wstart_b = '0;
    end else begin
      cnt_b    = cnt_q;
      ovf_b    = ovf_q;
      first_b  = first_q;
      last_b   = last_q;
      widest_b = widest_q;
      wstart_b = wstart_q;
    end
    cnt_n    = cnt_b;
    ovf_n    = ovf_b;
    first_n  = first_b;
    last_n   = last_b;
    widest_n = widest_b;
    wstart_n = wstart_b;
    run      = flip_coord - last_b;
    if (flip) begin
      if (cnt_b == FLIP_WIDTH'(MAX_FLIPS)) ovf_n = 1'b1;
      else                                 cnt_n = cnt_b + 1'b1;
      // Strictly-greater keeps the earliest of equally wide runs.
      if ((cnt_b == '0) && !ovf_b) begin
        first_n = flip_coord;
      end else if (run > widest_b) begin
        widest_n = run;
        wstart_n = last_b;
      end
      last_n = flip_coord;
    end
    centre_sum = {1'b0, first_n} + {1'b0, last_n};
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                <= ST_IDLE;
      coord_q              <= '0;
      cnt_q                <= '0;
      ovf_q                <= 1'b0;
      first_q              <= '0;
      last_q               <= '0;
      widest_q             <= '0;
      wstart_q             <= '0;
      number_of_flips_out  <= '0;
      overflow_out         <= 1'b0;
      first_coord_out      <= '0;
      last_coord_out       <= '0;
      centre_coord_out     <= '0;
      widest_run_out       <= '0;
      widest_run_start_out <= '0;
      done_out             <= 1'b0;
    end else begin
      done_out <= 1'b0;
      if (accept) begin
        coord_q  <= cur_coord + 1'b1;
        cnt_q    <= cnt_n;
        ovf_q    <= ovf_n;
        first_q  <= first_n;
        last_q   <= last_n;
        widest_q <= widest_n;
        wstart_q <= wstart_n;
        state    <= line_end ? ST_IDLE : ST_SCAN;
        if (line_end) begin
          number_of_flips_out  <= cnt_n;
          overflow_out         <= ovf_n;
          first_coord_out      <= first_n;
          last_coord_out       <= last_n;
          centre_coord_out     <= centre_sum[COORD_WIDTH:1];
          widest_run_out       <= widest_n;
          widest_run_start_out <= wstart_n;
          done_out             <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_run_length_marker_scan.sv
// Bench for run_length_marker_scan: three configurations share one stimulus
// stream; table lines run back-to-back, then restart, stall and reset cases.
module tb_run_length_marker_scan;
  import marker_pkg::*;

  localparam int PW = 3;
  localparam int CW = 11;
  localparam int LL = 16;

  typedef struct packed {
    logic [31:0] flips;
    logic [31:0] ovf;
    logic [31:0] first;
    logic [31:0] last;
    logic [31:0] centre;
    logic [31:0] widest;
    logic [31:0] wstart;
  } res_t;

  typedef struct {
    string pix;
    int    sel;
    res_t  exp;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          pv;
  logic          ls;
  logic [PW-1:0] rgb;

  // dut_a: MIN_RUN=2 MAX_FLIPS=15; dut_b: MIN_RUN=1; dut_c: MAX_FLIPS=3
  logic [3:0]    flips_a, flips_b;
  logic [1:0]    flips_c;
  logic          ovf_a, ovf_b, ovf_c, done_a, done_b, done_c;
  logic [CW-1:0] first_a, last_a, centre_a, widest_a, wstart_a;
  logic [CW-1:0] first_b, last_b, centre_b, widest_b, wstart_b;
  logic [CW-1:0] first_c, last_c, centre_c, widest_c, wstart_c;
  scan_state_t   st_a, st_b, st_c;

  int n_cmp  = 0;
  int n_fail = 0;
  res_t got_a[$];
  res_t got_b[$];
  res_t got_c[$];

  always #5 clk = ~clk;

  run_length_marker_scan #(.PIXEL_WIDTH(PW), .COORD_WIDTH(CW), .LINE_LENGTH(LL),
    .MAX_FLIPS(15), .MIN_RUN(2)) dut_a (
    .clk_in(clk), .rst_in(rst), .pixel_valid_in(pv), .line_start_in(ls), .rgb_in(rgb),
    .number_of_flips_out(flips_a), .overflow_out(ovf_a), .first_coord_out(first_a),
    .last_coord_out(last_a), .centre_coord_out(centre_a), .widest_run_out(widest_a),
    .widest_run_start_out(wstart_a), .done_out(done_a), .state_out(st_a));

  run_length_marker_scan #(.PIXEL_WIDTH(PW), .COORD_WIDTH(CW), .LINE_LENGTH(LL),
    .MAX_FLIPS(15), .MIN_RUN(1)) dut_b (
    .clk_in(clk), .rst_in(rst), .pixel_valid_in(pv), .line_start_in(ls), .rgb_in(rgb),
    .number_of_flips_out(flips_b), .overflow_out(ovf_b), .first_coord_out(first_b),
    .last_coord_out(last_b), .centre_coord_out(centre_b), .widest_run_out(widest_b),
    .widest_run_start_out(wstart_b), .done_out(done_b), .state_out(st_b));

  run_length_marker_scan #(.PIXEL_WIDTH(PW), .COORD_WIDTH(CW), .LINE_LENGTH(LL),
    .MAX_FLIPS(3), .MIN_RUN(2)) dut_c (
    .clk_in(clk), .rst_in(rst), .pixel_valid_in(pv), .line_start_in(ls), .rgb_in(rgb),
    .number_of_flips_out(flips_c), .overflow_out(ovf_c), .first_coord_out(first_c),
    .last_coord_out(last_c), .centre_coord_out(centre_c), .widest_run_out(widest_c),
    .widest_run_start_out(wstart_c), .done_out(done_c), .state_out(st_c));

  function automatic res_t mk(int f, int o, int fi, int la, int ce, int wi, int ws);
    res_t r;
    r.flips  = 32'(f);
    r.ovf    = 32'(o);
    r.first  = 32'(fi);
    r.last   = 32'(la);
    r.centre = 32'(ce);
    r.widest = 32'(wi);
    r.wstart = 32'(ws);
    return r;
  endfunction

  function automatic res_t res_of(int sel);
    case (sel)
      0:       return mk(int'(flips_a), int'(ovf_a), int'(first_a), int'(last_a),
                         int'(centre_a), int'(widest_a), int'(wstart_a));
      1:       return mk(int'(flips_b), int'(ovf_b), int'(first_b), int'(last_b),
                         int'(centre_b), int'(widest_b), int'(wstart_b));
      default: return mk(int'(flips_c), int'(ovf_c), int'(first_c), int'(last_c),
                         int'(centre_c), int'(widest_c), int'(wstart_c));
    endcase
  endfunction

  // Capture each DUT's results whenever its done pulse is seen.
  always @(negedge clk) begin
    if (done_a) got_a.push_back(res_of(0));
    if (done_b) got_b.push_back(res_of(1));
    if (done_c) got_c.push_back(res_of(2));
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_res(string tag, res_t act, res_t exp);
    check({tag, ".flips"},  act.flips,  exp.flips);
    check({tag, ".ovf"},    act.ovf,    exp.ovf);
    check({tag, ".first"},  act.first,  exp.first);
    check({tag, ".last"},   act.last,   exp.last);
    check({tag, ".centre"}, act.centre, exp.centre);
    check({tag, ".widest"}, act.widest, exp.widest);
    check({tag, ".wstart"}, act.wstart, exp.wstart);
  endtask

  task automatic step(bit v, bit l, logic [PW-1:0] p);
    @(negedge clk);
    pv  = v;
    ls  = l;
    rgb = p;
  endtask

  // Drives pixels 0..n-1 of a line string, optionally stalling after one coord.
  task automatic run_line(string s, int n, int stall_after, int stall_len);
    for (int i = 0; i < n; i++) begin
      step(1'b1, i == 0, PW'(s[i] - 8'h30));
      if (i == stall_after)
        for (int j = 0; j < stall_len; j++)
          step(1'b0, 1'($urandom_range(0, 1)), PW'($urandom_range(0, 7)));
    end
  endtask

  vec_t vecs[10];
  res_t exp1;
  int   base;

  initial begin
    exp1 = mk(3, 0, 4, 12, 8, 4, 4);
    vecs[0] = '{"0000777700007777", 0, exp1};
    vecs[1] = '{"0000070000000000", 0, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[2] = '{"0000070000000000", 1, mk(2, 0, 5, 6, 5, 1, 5)};
    vecs[3] = '{"0077007700770077", 2, mk(3, 1, 2, 14, 8, 2, 2)};
    vecs[4] = '{"0123456701234567", 1, mk(15, 0, 1, 15, 8, 1, 1)};
    vecs[5] = '{"0000000000000077", 0, mk(1, 0, 14, 14, 14, 0, 0)};
    vecs[6] = '{"0077000000777777", 0, mk(3, 0, 2, 10, 6, 6, 4)};
    vecs[7] = '{"0000350000000000", 0, mk(0, 0, 0, 0, 0, 0, 0)};
    vecs[8] = '{"0000335555000000", 0, mk(3, 0, 4, 10, 7, 4, 6)};
    vecs[9] = '{"0000000000000007", 0, mk(0, 0, 0, 0, 0, 0, 0)};

    rst = 1'b1;
    pv  = 1'b0;
    ls  = 1'b0;
    rgb = '0;
    repeat (3) @(negedge clk);
    check_res("reset", res_of(0), mk(0, 0, 0, 0, 0, 0, 0));
    check("reset.done", 32'(done_a), 32'd0);
    check("reset.state", 32'(st_a), 32'(ST_IDLE));
    rst = 1'b0;

    // Valid pixels without a line start must not start a scan.
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 3'd7);
    step(1'b0, 1'b0, 3'd0);
    check("idle_no_start.state", 32'(st_a), 32'(ST_IDLE));

    // Table lines back-to-back: each line start lands on the previous done cycle.
    for (int k = 0; k < 10; k++) run_line(vecs[k].pix, LL, -1, 0);
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    check("table.count_a", 32'(got_a.size()), 32'd10);
    check("table.count_b", 32'(got_b.size()), 32'd10);
    check("table.count_c", 32'(got_c.size()), 32'd10);
    for (int k = 0; k < 10; k++) begin
      res_t g;
      case (vecs[k].sel)
        0:       g = (k < got_a.size()) ? got_a[k] : '1;
        1:       g = (k < got_b.size()) ? got_b[k] : '1;
        default: g = (k < got_c.size()) ? got_c[k] : '1;
      endcase
      check_res($sformatf("table%0d", k), g, vecs[k].exp);
    end

    // Line abandoned by a new line start at coord 9.
    base = got_a.size();
    run_line("7700770077000000", 9, -1, 0);
    run_line("0000777700007777", LL, -1, 0);
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    check("restart.dones", 32'(got_a.size() - base), 32'd1);
    check_res("restart", (got_a.size() > 0) ? got_a[$] : '1, exp1);

    // Five invalid cycles after coord 6; done exactly one cycle after the last pixel.
    base = got_a.size();
    run_line("0000777700007777", 15, 6, 5);
    @(negedge clk);
    check("stall.done_early", 32'(done_a), 32'd0);
    pv  = 1'b1;
    ls  = 1'b0;
    rgb = 3'd7;
    @(negedge clk);
    check("stall.done_timing", 32'(done_a), 32'd1);
    check_res("stall", res_of(0), exp1);
    pv = 1'b0;
    @(negedge clk);
    check("stall.done_width", 32'(done_a), 32'd0);
    check("stall.dones", 32'(got_a.size() - base), 32'd1);

    // Reset at coord 10 after two committed flips.
    base = got_a.size();
    run_line("0000777700007777", 11, -1, 0);
    @(negedge clk);
    rst = 1'b1;
    pv  = 1'b0;
    @(negedge clk);
    check_res("midreset", res_of(0), mk(0, 0, 0, 0, 0, 0, 0));
    check("midreset.state", 32'(st_a), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("midreset.dones", 32'(got_a.size() - base), 32'd0);
    run_line("0000000077770000", LL, -1, 0);
    @(negedge clk);
    pv = 1'b0;
    check("after_reset.done", 32'(done_a), 32'd1);
    check_res("after_reset", res_of(0), mk(2, 0, 8, 12, 10, 4, 8));

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
